// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: buffered entry layout and fetch state.
package fetch_pkg;

    localparam int INSTR_BYTES = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        F_RUN,
        F_HALTED,
        F_FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc,word} entries. Flush beats push and pop.
// When empty, the head output keeps showing the last entry that was popped.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    fetch_entry_t   last_q, last_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? last_q : mem_q[rd_ptr_q];

    // Next-state for storage, pointers, occupancy and the held head value.
    always_comb begin
        mem_d    = mem_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                last_d   = mem_q[rd_ptr_q];
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    // Control state and the visible held value return to zero on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Entry storage carries no reset; only slots behind valid pointers are ever read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction memory address from the PC, buffers
// fetched {pc,word} pairs and hands them to decode with valid/ready.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES  = 64,
    parameter int RESET_PC   = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_word,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_word,
    output logic [15:0] ir_pc,
    output logic        fault
);

    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic         fault_q, fault_d;
    logic [15:0]  pc_plus;
    logic         push, pop;
    logic         fifo_empty, fifo_full;
    fetch_state_t state;
    fetch_entry_t fifo_din, fifo_head;

    // A latched fault outranks halt; otherwise halt simply suspends fetching.
    always_comb begin
        if (fault_q)   state = F_FAULT;
        else if (halt) state = F_HALTED;
        else           state = F_RUN;
    end

    assign imem_addr = fetch_pc_q;
    assign pop       = ir_valid && ir_ready;
    assign push      = (state == F_RUN) && !redirect_valid && (!fifo_full || pop);
    assign fifo_din  = '{pc: fetch_pc_q, word: imem_word};
    assign pc_plus   = fetch_pc_q + 16'(INSTR_BYTES);

    // Next PC and fault: redirect wins, bad targets latch the fault and keep the PC.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            if (!redirect_pc[0] && (redirect_pc < 16'(MEM_BYTES))) fetch_pc_d = redirect_pc;
            else                                                  fault_d    = 1'b1;
        end else if (push) begin
            fetch_pc_d = (pc_plus == 16'(MEM_BYTES)) ? 16'h0000 : pc_plus;
        end
    end

    // PC and sticky fault registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= 16'(RESET_PC);
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ir_valid = !fifo_empty;
    assign ir_word  = fifo_head.word;
    assign ir_pc    = fifo_head.pc;
    assign fault    = fault_q;

endmodule
